// File: rtl/i_mem_ld.sv
// Instruction memory with a loader write port and a one-deep fetch result register.
// Fetch latency: 1 cycle from accept to f_valid. After reset the memory spends DEPTH cycles clearing itself.
// Backpressure: f_stall holds a presented result, and f_ready stays low until the consumer takes it.
module i_mem_ld #(
  parameter int                DATA_W    = 32,
  parameter int                ADDR_W    = 8,
  parameter int                DEPTH     = 256,
  parameter logic [DATA_W-1:0] INIT_WORD = DATA_W'(32'h0000_0000)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_ready,
  input  logic              f_stall,
  output logic              f_valid,
  output logic [DATA_W-1:0] f_data,
  output logic              f_err,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  output logic              busy
);

  // The clear pointer stops at DEPTH-1. The range checks use one extra bit so that DEPTH == 2**ADDR_W works.
  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   DEPTH_X  = (ADDR_W + 1)'(DEPTH);

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_e;

  state_e              state_q;
  logic [ADDR_W-1:0]   ptr_q;
  logic [DATA_W-1:0]   mem_q [DEPTH];

  logic                f_valid_q;
  logic [DATA_W-1:0]   f_data_q;
  logic                f_err_q;
  logic [DATA_W-1:0]   f_data_d;
  logic                f_err_d;

  logic                f_in_range;
  logic                ld_in_range;
  logic                ld_wr;
  logic                hold;
  logic                accept;

  assign f_in_range  = ({1'b0, f_addr}  < DEPTH_X);
  assign ld_in_range = ({1'b0, ld_addr} < DEPTH_X);
  assign ld_wr       = (state_q == RUN) && ld_we && ld_in_range;
  assign hold        = f_valid_q && f_stall;
  assign f_ready     = (state_q == RUN) && !hold;
  assign accept      = f_req && f_ready;

  assign busy    = (state_q == CLEAR);
  assign f_valid = f_valid_q;
  assign f_data  = f_data_q;
  assign f_err   = f_err_q;

  // Read data for an accepted fetch. A same-cycle loader write to the same word bypasses the array, so the new data is returned.
  always_comb begin
    f_err_d  = !f_in_range;
    f_data_d = INIT_WORD;
    if (f_in_range) begin
      if (ld_wr && (ld_addr == f_addr)) begin
        f_data_d = ld_data;
      end else begin
        f_data_d = mem_q[f_addr];
      end
    end
  end

  // Single write port: it clears the array during CLEAR and carries loader writes during RUN.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_q == CLEAR) begin
        mem_q[ptr_q] <= INIT_WORD;
      end else if (ld_wr) begin
        mem_q[ld_addr] <= ld_data;
      end
    end
  end

  // Control FSM and fetch result register. A stall freezes a valid result, and a reset drops it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= CLEAR;
      ptr_q     <= '0;
      f_valid_q <= 1'b0;
      f_data_q  <= '0;
      f_err_q   <= 1'b0;
    end else begin
      case (state_q)
        CLEAR: begin
          f_valid_q <= 1'b0;
          if (ptr_q == LAST_PTR) begin
            state_q <= RUN;
            ptr_q   <= '0;
          end else begin
            ptr_q <= ptr_q + ADDR_W'(1);
          end
        end
        RUN: begin
          if (accept) begin
            f_valid_q <= 1'b1;
            f_data_q  <= f_data_d;
            f_err_q   <= f_err_d;
          end else if (!hold) begin
            f_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q <= CLEAR;
          ptr_q   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i_mem_ld.sv
// Directed bench for i_mem_ld: a default instance, plus a DEPTH=200 instance with a non-zero fill word.
// Inputs are driven 1 time unit after the rising edge. Outputs are sampled at the same point.
// Each comparison is an immediate assertion whose action counts and reports the failure.
module tb_i_mem_ld;

  localparam logic [31:0] B_INIT = 32'hA5A5_0013;

  logic        clk = 1'b0;

  logic        rst, f_req, f_stall, ld_we;
  logic [7:0]  f_addr, ld_addr;
  logic [31:0] ld_data;
  logic        f_ready, f_valid, f_err, busy;
  logic [31:0] f_data;

  logic        b_rst, b_f_req, b_f_stall, b_ld_we;
  logic [7:0]  b_f_addr, b_ld_addr;
  logic [31:0] b_ld_data;
  logic        b_f_ready, b_f_valid, b_f_err, b_busy;
  logic [31:0] b_f_data;

  int n_cmp = 0;
  int n_err = 0;
  int n;

  always #5 clk = ~clk;

  i_mem_ld dut_a (
    .clk(clk), .rst(rst), .f_req(f_req), .f_addr(f_addr), .f_ready(f_ready),
    .f_stall(f_stall), .f_valid(f_valid), .f_data(f_data), .f_err(f_err),
    .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data), .busy(busy)
  );

  i_mem_ld #(.DATA_W(32), .ADDR_W(8), .DEPTH(200), .INIT_WORD(B_INIT)) dut_b (
    .clk(clk), .rst(b_rst), .f_req(b_f_req), .f_addr(b_f_addr), .f_ready(b_f_ready),
    .f_stall(b_f_stall), .f_valid(b_f_valid), .f_data(b_f_data), .f_err(b_f_err),
    .ld_we(b_ld_we), .ld_addr(b_ld_addr), .ld_data(b_ld_data), .busy(b_busy)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1; f_req = 0; f_addr = 0; f_stall = 0; ld_we = 0; ld_addr = 0; ld_data = 0;
    b_rst = 1; b_f_req = 0; b_f_addr = 0; b_f_stall = 0; b_ld_we = 0; b_ld_addr = 0; b_ld_data = 0;
    step(); step();

    // Check the reset state.
    chk("rst_valid", f_valid, 0);
    chk("rst_data",  f_data, 0);
    chk("rst_err",   f_err, 0);
    chk("rst_busy",  busy, 1);
    chk("rst_ready", f_ready, 0);

    // Release reset. busy should stay high for exactly 256 sampled cycles.
    rst = 0;
    n = 0;
    while (busy && n < 1000) begin step(); n++; end
    chk("clear_cycles", n, 256);

    // Fetch address 5 from the cleared memory.
    f_req = 1; f_addr = 8'd5; #1;
    chk("run_ready", f_ready, 1);
    step(); f_req = 0;
    chk("f5_valid", f_valid, 1);
    chk("f5_data",  f_data, 32'h0);
    chk("f5_err",   f_err, 0);
    step();
    chk("idle_valid", f_valid, 0);

    // Load a word, then fetch it back.
    ld_we = 1; ld_addr = 8'd1; ld_data = 32'h0016_8033;
    step(); ld_we = 0;
    f_req = 1; f_addr = 8'd1;
    step(); f_req = 0;
    chk("f1_valid", f_valid, 1);
    chk("f1_data",  f_data, 32'h0016_8033);

    // Write and fetch the same address in the same cycle. The new data should be returned.
    ld_we = 1; ld_addr = 8'd2; ld_data = 32'h0016_8032;
    f_req = 1; f_addr = 8'd2;
    step(); ld_we = 0; f_req = 0;
    chk("wf_data", f_data, 32'h0016_8032);
    chk("wf_err",  f_err, 0);
    step();
    chk("keep_valid", f_valid, 0);
    chk("keep_data",  f_data, 32'h0016_8032);

    // Stall hold while a loader write hits the held address.
    f_req = 1; f_addr = 8'd1;
    step();
    chk("st_first", f_data, 32'h0016_8033);
    f_stall = 1; ld_we = 1; ld_addr = 8'd1; ld_data = 32'hDEAD_BEEF; #1;
    chk("st_ready0", f_ready, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("st_valid", f_valid, 1);
      chk("st_data",  f_data, 32'h0016_8033);
      chk("st_ready", f_ready, 0);
    end
    f_stall = 0; ld_we = 0; f_req = 0; #1;
    chk("st_rel_ready", f_ready, 1);
    step();
    chk("st_rel_valid", f_valid, 0);
    f_req = 1; f_addr = 8'd1;
    step(); f_req = 0;
    chk("st_new_data", f_data, 32'hDEAD_BEEF);

    // A stall has no effect when no result is valid.
    step();
    f_stall = 1; f_req = 1; f_addr = 8'd2; #1;
    chk("st_inv_ready", f_ready, 1);
    step(); f_req = 0;
    chk("st_inv_data", f_data, 32'h0016_8032);
    step();
    chk("st_inv_hold", f_valid, 1);
    f_stall = 0;

    // Reset during RUN. Loader writes during the clear should be ignored.
    rst = 1;
    step(); rst = 0;
    chk("mrst_valid", f_valid, 0);
    chk("mrst_data",  f_data, 0);
    chk("mrst_busy",  busy, 1);
    ld_we = 1; ld_addr = 8'd1; ld_data = 32'hAAAA_5555; f_req = 1; f_addr = 8'd3; #1;
    chk("mrst_ready", f_ready, 0);
    n = 0;
    while (busy && n < 1000) begin step(); n++; end
    chk("mrst_cycles", n, 256);
    chk("mrst_novalid", f_valid, 0);
    ld_we = 0; f_req = 1; f_addr = 8'd1;
    step(); f_addr = 8'd2;
    chk("mrst_f1", f_data, 32'h0);
    step(); f_req = 0;
    chk("mrst_f2", f_data, 32'h0);

    // Instance B: DEPTH=200 with a non-zero fill word.
    b_rst = 0;
    n = 0;
    while (b_busy && n < 1000) begin step(); n++; end
    chk("b_clear_cycles", n, 200);
    b_ld_we = 1; b_ld_addr = 8'd199; b_ld_data = 32'h0000_0011;
    step();
    b_ld_addr = 8'd250; b_ld_data = 32'h1234_5678;
    step(); b_ld_we = 0;
    b_f_req = 1; b_f_addr = 8'd200;
    step(); b_f_addr = 8'd199;
    chk("b_f200_err",  b_f_err, 1);
    chk("b_f200_data", b_f_data, B_INIT);
    step(); b_f_addr = 8'd250;
    chk("b_f199_data", b_f_data, 32'h0000_0011);
    chk("b_f199_err",  b_f_err, 0);
    step(); b_f_addr = 8'd50;
    chk("b_f250_data", b_f_data, B_INIT);
    chk("b_f250_err",  b_f_err, 1);
    step(); b_f_addr = 8'd0;
    chk("b_f50_data", b_f_data, B_INIT);
    chk("b_f50_err",  b_f_err, 0);
    step(); b_f_req = 0;
    chk("b_f0_data", b_f_data, B_INIT);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/i_mem_ld.md
I_MEM_LD -- requirements
Module: i_mem_ld

Interface
REQ-001 SHALL have parameter DATA_W, default 32, instruction word width in bits.
REQ-002 SHALL have parameter ADDR_W, default 8, word address width.
REQ-003 SHALL have parameter DEPTH, default 256, number of words; legal range 1..2**ADDR_W.
REQ-004 SHALL have parameter INIT_WORD, default 32'h00000000 (NOP), fill value after reset.
REQ-005 SHALL have port clk  in  1  sole clock; all state updates on rising edge.
REQ-006 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-007 SHALL have port f_req  in  1  fetch request.
REQ-008 SHALL have port f_addr  in  ADDR_W  fetch word address.
REQ-009 SHALL have port f_ready  out  1  fetch request accepted this cycle when high.
REQ-010 SHALL have port f_stall  in  1  consumer hold; freezes the presented result.
REQ-011 SHALL have port f_valid  out  1  f_data/f_err hold a fetch result.
REQ-012 SHALL have port f_data  out  DATA_W  fetched instruction word.
REQ-013 SHALL have port f_err  out  1  fetched address was >= DEPTH.
REQ-014 SHALL have port ld_we  in  1  loader write enable.
REQ-015 SHALL have port ld_addr  in  ADDR_W  loader word address.
REQ-016 SHALL have port ld_data  in  DATA_W  loader write data.
REQ-017 SHALL have port busy  out  1  memory clear in progress.

Function
REQ-018 SHALL implement two states, CLEAR and RUN; rst forces CLEAR with clear pointer = 0.
REQ-019 In CLEAR, SHALL write INIT_WORD to mem[pointer] each cycle and increment the pointer; after writing word DEPTH-1, SHALL go to RUN on the next edge (exactly DEPTH cycles in CLEAR).
REQ-020 busy SHALL be 1 in CLEAR and 0 in RUN; in CLEAR f_ready=0 and ld_we is ignored.
REQ-021 In RUN, f_ready SHALL be combinational: 1 unless (f_valid and f_stall).
REQ-022 Fetch accept = f_req and f_ready; accepted fetch SHALL produce f_valid=1 with f_data/f_err on the next edge (latency 1).
REQ-023 With no accept and no stall hold, f_valid SHALL go 0 on the next edge; f_data SHALL keep its last value.
REQ-024 While f_valid=1 and f_stall=1, f_valid/f_data/f_err SHALL hold unchanged; f_stall with f_valid=0 has no effect.
REQ-025 Accepted f_addr >= DEPTH SHALL return f_data=INIT_WORD with f_err=1; otherwise f_err=0.
REQ-026 In RUN, ld_we with ld_addr < DEPTH SHALL write ld_data to mem[ld_addr]; ld_addr >= DEPTH SHALL be ignored.
REQ-027 Write and accepted fetch to the same address in the same cycle SHALL return the new ld_data (write-first).
REQ-028 Loader writes during a stall hold SHALL be performed but SHALL NOT alter the held f_data.
REQ-029 Storage SHALL be DEPTH x DATA_W registers/RAM with one write port and one read port.

Reset
REQ-030 On rst: f_valid=0, f_data=0, f_err=0, busy=1, state=CLEAR, pointer=0 at the next edge.
REQ-031 rst asserted mid-operation (CLEAR or RUN, stalled or not) SHALL abort, discard any pending result and restart the full clear; all previously loaded words read as INIT_WORD afterwards.

Verification
REQ-032 Defaults; release rst -> busy=1 for exactly 256 cycles then 0; fetch addr 5 -> next cycle f_valid=1, f_data=0x00000000, f_err=0.
REQ-033 Load addr 1 = 0x00168033; fetch addr 1 next cycle -> f_data=0x00168033 one cycle after accept.
REQ-034 Same cycle: ld addr 2 = 0x00168032 and fetch addr 2 -> f_data=0x00168032.
REQ-035 Fetch addr 1 (0x00168033), hold f_stall=1 for 3 cycles while loading addr 1 = 0xDEADBEEF -> f_ready=0, f_data stays 0x00168033; after release, fetch addr 1 -> 0xDEADBEEF.
REQ-036 DEPTH=200: fetch addr 200 -> f_err=1, f_data=INIT_WORD; ld addr 250 = 0x12345678 has no effect on any word.
REQ-037 After loads, pulse rst during RUN -> busy=1 for DEPTH cycles, ld_we ignored meanwhile; then fetch addr 1 -> 0x00000000.
